// File: rtl/booth_multiplier_if.sv
// Operand/result bundle for booth_multiplier; the requester drives start and operands.
// MULT_FULL_PRODUCT_EN adds data_result_hi carrying the upper product word.
interface booth_multiplier_if;
  localparam int unsigned OP_W = 32;

  logic            ctrl_MULT;
  logic [OP_W-1:0] data_operandA;
  logic [OP_W-1:0] data_operandB;
  logic [OP_W-1:0] data_result;
  logic            data_exception;
  logic            data_resultRDY;
`ifdef MULT_FULL_PRODUCT_EN
  logic [OP_W-1:0] data_result_hi;
`endif

`ifdef MULT_FULL_PRODUCT_EN
  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, data_result_hi
  );
  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, data_result_hi
  );
`else
  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );
  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
`endif
endinterface

// File: rtl/booth_multiplier.sv
// 32x32 signed radix-4 Booth multiplier, 16 steps per product, one-cycle ready pulse.
// MULT_FULL_PRODUCT_EN exposes the upper product word on data_result_hi.
module booth_multiplier (
  input  logic              clock,
  input  logic              reset,
  booth_multiplier_if.slave bus
);
  localparam int unsigned OP_W  = 32;
  localparam int unsigned ACC_W = OP_W + 2;
  localparam int unsigned P_W   = ACC_W + OP_W + 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(15);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]  p_q, p_d;
  logic [OP_W-1:0] m_q, m_d;
  logic [OP_W-1:0] result_q, result_d;
  logic            exc_q, exc_d;
  logic            rdy_q, rdy_d;
`ifdef MULT_FULL_PRODUCT_EN
  logic [OP_W-1:0] result_hi_q, result_hi_d;
`endif

  logic [ACC_W-1:0] m_ext;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_sum;
  logic [P_W-1:0]   p_add;
  logic [P_W-1:0]   p_step;
  logic             p_step_exc;

  // Booth digit from the low three bits of P selects the partial product.
  always_comb begin
    m_ext = {{(ACC_W-OP_W){m_q[OP_W-1]}}, m_q};
    term  = '0;
    case (p_q[2:0])
      3'b001, 3'b010: term = m_ext;
      3'b011:         term = ACC_W'(m_ext << 1);
      3'b100:         term = ACC_W'(-(m_ext << 1));
      3'b101, 3'b110: term = ACC_W'(-m_ext);
      default:        term = '0;
    endcase
    acc_sum    = ACC_W'(p_q[P_W-1:OP_W+1] + term);
    p_add      = {acc_sum, p_q[OP_W:0]};
    p_step     = {{2{p_add[P_W-1]}}, p_add[P_W-1:2]};
    p_step_exc = (p_step[2*OP_W:OP_W+1] != {OP_W{p_step[OP_W]}});
  end

  // Next-state: a start request always wins and reloads, even mid-run.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    m_d      = m_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef MULT_FULL_PRODUCT_EN
    result_hi_d = result_hi_q;
`endif
    if (bus.ctrl_MULT) begin
      state_d = RUN;
      cnt_d   = '0;
      p_d     = {{ACC_W{1'b0}}, bus.data_operandB, 1'b0};
      m_d     = bus.data_operandA;
    end else begin
      case (state_q)
        RUN: begin
          p_d   = p_step;
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            rdy_d    = 1'b1;
            result_d = p_step[OP_W:1];
            exc_d    = p_step_exc;
`ifdef MULT_FULL_PRODUCT_EN
            result_hi_d = p_step[2*OP_W:OP_W+1];
`endif
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef MULT_FULL_PRODUCT_EN
      result_hi_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      m_q      <= m_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef MULT_FULL_PRODUCT_EN
      result_hi_q <= result_hi_d;
`endif
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
`ifdef MULT_FULL_PRODUCT_EN
  assign bus.data_result_hi = result_hi_q;
`endif

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier: timing of the ready pulse, products, restart and reset.
module tb_booth_multiplier;
  logic clock;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  booth_multiplier_if bus ();

  booth_multiplier dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] r, input logic e,
                              input logic [31:0] hi);
    check({tag, " result"}, 64'(bus.data_result), 64'(r));
    check({tag, " exception"}, 64'(bus.data_exception), 64'(e));
`ifdef MULT_FULL_PRODUCT_EN
    check({tag, " result_hi"}, 64'(bus.data_result_hi), 64'(hi));
`else
    if (hi === 32'hx) $display("unreachable");
`endif
  endtask

  // Present operands for one edge (E0), then scramble them to show they are ignored.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
  endtask

  // From the negedge after E0: ready only after E16, results then held after E17.
  task automatic wait_done(input string tag, input logic [31:0] r, input logic e,
                           input logic [31:0] hi);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      check({tag, " rdy"}, 64'(bus.data_resultRDY), 64'(k == 16));
    end
    check_result(tag, r, e, hi);
    @(negedge clock);
    check({tag, " rdy drop"}, 64'(bus.data_resultRDY), 64'd0);
    check_result({tag, " hold"}, r, e, hi);
  endtask

  initial begin
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset rdy", 64'(bus.data_resultRDY), 64'd0);
    check_result("reset", 32'h0, 1'b0, 32'h0);

    // 3*5, with a new start (-7*6) sampled during the DONE cycle.
    launch(32'd3, 32'd5);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      check("3x5 rdy", 64'(bus.data_resultRDY), 64'd0);
    end
    @(negedge clock);
    check("3x5 rdy", 64'(bus.data_resultRDY), 64'd1);
    check_result("3x5", 32'h0000000F, 1'b0, 32'h0);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'hFFFFFFF9;
    bus.data_operandB = 32'd6;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
    check("3x5 rdy single", 64'(bus.data_resultRDY), 64'd0);
    check_result("3x5 held", 32'h0000000F, 1'b0, 32'h0);
    wait_done("-7x6", 32'hFFFFFFD6, 1'b0, 32'hFFFFFFFF);

    launch(32'h7FFFFFFF, 32'd2);
    wait_done("maxx2", 32'hFFFFFFFE, 1'b1, 32'h00000000);
    launch(32'h80000000, 32'hFFFFFFFF);
    wait_done("minx-1", 32'h80000000, 1'b1, 32'h00000000);
    launch(32'h80000000, 32'h80000000);
    wait_done("minxmin", 32'h00000000, 1'b1, 32'h40000000);
    launch(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("-1x-1", 32'h00000001, 1'b0, 32'h00000000);
    launch(32'h00000000, 32'h12345678);
    wait_done("0xN", 32'h00000000, 1'b0, 32'h00000000);

    // Restart at E5: only the second operation reports, 16 edges after E5.
    launch(32'd9, 32'd9);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check("abort rdy", 64'(bus.data_resultRDY), 64'd0);
    end
    launch(32'd4, 32'hFFFFFFFC);
    wait_done("4x-4", 32'hFFFFFFF0, 1'b0, 32'hFFFFFFFF);

    // Reset at E8 with a simultaneous start: reset wins, nothing ever reports.
    launch(32'd9, 32'd9);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check("pre-reset rdy", 64'(bus.data_resultRDY), 64'd0);
    end
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd123;
    bus.data_operandB = 32'd456;
    @(negedge clock);
    reset         = 1'b0;
    bus.ctrl_MULT = 1'b0;
    check("mid reset rdy", 64'(bus.data_resultRDY), 64'd0);
    check_result("mid reset", 32'h0, 1'b0, 32'h0);
    for (int k = 9; k <= 30; k++) begin
      @(negedge clock);
      check("post reset rdy", 64'(bus.data_resultRDY), 64'd0);
      check("post reset result", 64'(bus.data_result), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 SHALL have port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ctrl_MULT, input, 1 bit: start request, sampled on each rising edge.
REQ-004 SHALL have port data_operandA, input, 32 bits: signed multiplicand, captured when ctrl_MULT is sampled high.
REQ-005 SHALL have port data_operandB, input, 32 bits: signed multiplier, captured when ctrl_MULT is sampled high.
REQ-006 SHALL have port data_result, output, 32 bits: low 32 bits of the signed product.
REQ-007 SHALL have port data_exception, output, 1 bit: high when the 64-bit product does not fit in signed 32 bits.
REQ-008 SHALL have port data_resultRDY, output, 1 bit: one-cycle pulse marking data_result and data_exception valid.

Function
REQ-009 SHALL implement the FSM states IDLE, RUN and DONE, with a 4-bit internal iteration counter.
REQ-010 SHALL load the 67-bit product register P on the edge E0 where ctrl_MULT is sampled high:
- P[66:33] = 0, P[32:1] = data_operandB, P[0] = 0.
- The multiplicand M = data_operandA is latched on the same edge.
- The counter is set to 0 and the state goes to RUN.
REQ-011 SHALL perform one radix-4 Booth step per edge in RUN, using the Booth digit selected by P[2:0]:
- 000 or 111: add 0.
- 001 or 010: add +M.
- 011: add +2M.
- 100: add -2M.
- 101 or 110: add -M.
- The term is sign-extended to 34 bits and added to P[66:33] modulo 2^34.
- P is then arithmetic-shifted right by 2.
REQ-012 SHALL perform exactly 16 steps, on edges E1..E16; the counter increments on each step and the state goes to DONE on E16.
REQ-013 SHALL assert data_resultRDY for exactly one cycle, from E16 to E17, then return to IDLE.
REQ-014 SHALL drive data_result = P[32:1] once the operation completes.
REQ-015 SHALL set data_exception when P[64:33] is not all equal to P[32], i.e. the product is not sign-representable in 32 bits.
REQ-016 SHALL hold data_result and data_exception stable from DONE until the next ctrl_MULT is sampled high.
REQ-017 SHALL restart when ctrl_MULT is sampled high during RUN:
- The current operation is aborted and the new operands are loaded.
- No data_resultRDY pulse is produced for the aborted operation.
REQ-018 SHALL handle ctrl_MULT sampled high during the DONE cycle as follows:
- The data_resultRDY pulse for the completed operation still occurs.
- The new operation loads on that same edge.
REQ-019 SHALL ignore the operand inputs at all times other than the edge where ctrl_MULT is sampled high.
REQ-020 SHALL keep the counter wrap (15 to 0) internal; it is never visible, because the state leaves RUN on the 16th step.

Reset
REQ-021 SHALL, when reset is high on a rising edge, set the following regardless of state or ctrl_MULT:
- state = IDLE, counter = 0, P = 0, M = 0.
- data_result = 0, data_exception = 0, data_resultRDY = 0.
REQ-022 SHALL let reset take priority over a simultaneous ctrl_MULT; an operation interrupted by reset never produces data_resultRDY.

Configuration
REQ-023 SHALL, with MULT_FULL_PRODUCT_EN defined, add output port data_result_hi, 32 bits, driven with P[64:33] and governed by the same hold and reset rules as data_result.
REQ-024 SHALL, without MULT_FULL_PRODUCT_EN, omit data_result_hi; all other behaviour is identical in both builds.

Verification
REQ-025 SHALL cover: A=3, B=5, ctrl_MULT pulse at E0 -> data_resultRDY high only between E16 and E17; data_result=0x0000000F; data_exception=0.
REQ-026 SHALL cover: A=-7, B=6 -> data_result=0xFFFFFFD6; data_exception=0; with the macro, data_result_hi=0xFFFFFFFF.
REQ-027 SHALL cover: A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE; data_exception=1; with the macro, data_result_hi=0x00000000.
REQ-028 SHALL cover: A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000; data_exception=1.
REQ-029 SHALL cover: start A=9, B=9, then a second ctrl_MULT with A=4, B=-4 at E5 -> a single data_resultRDY pulse, 16 cycles after E5; data_result=0xFFFFFFF0.
REQ-030 SHALL cover: start an operation, assert reset at E8 -> all outputs 0 and no data_resultRDY through E30.
